jtag_rti_counter_dr: RTL

Parametrised JTAG user data register for the BSCANE2 USER chain. It holds CHANNELS independent Run-Test/Idle cycle counters, each individually enabled, saturating and with a sticky overflow flag. Host command and readback go through one DR scan of DATA_WIDTH+8 bits. It sits in the shell in place of the single-purpose user logic, and is wired directly to the BSCANE2 TCK/TDI/TDO and TAP-state outputs.

---
 rtl/jtag_rti_counter_dr.sv | 134 +++++++++++++
 1 files changed

// File: rtl/jtag_rti_counter_dr.sv
// JTAG USER data register with per-channel Run-Test/Idle cycle counters.
// One DR scan carries a command/status byte (LSB first) followed by a counter payload.
module jtag_rti_counter_dr #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 4
) (
  input  logic                  tck,
  input  logic                  test_logic_reset_n,
  input  logic                  tdi,
  output logic                  tdo,
  input  logic                  run_test_idle,
  input  logic                  ir_is_user,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  output logic [DATA_WIDTH-1:0] sel_count,
  output logic [CHANNELS-1:0]   overflow
);

  localparam int SR_W  = DATA_WIDTH + 8;
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_SELECT = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_ENABLE = 2'b11
  } opcode_t;

  // The ENABLE payload must hold one bit per channel, and sel must fit in 6 bits.
  generate
    if (CHANNELS > DATA_WIDTH || CHANNELS < 1 || CHANNELS > 64 ||
        DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_paramCheck
      $error("jtag_rti_counter_dr: unsupported DATA_WIDTH/CHANNELS combination");
    end
  endgenerate

  logic [SR_W-1:0]       r_sr;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_cmdError;
  logic [CHANNELS-1:0]   r_enable;

  logic [DATA_WIDTH-1:0] w_count [CHANNELS];
  logic [CHANNELS-1:0]   w_overflow;
  logic                  w_capture;
  logic                  w_shift;
  logic                  w_update;
  opcode_t               w_opcode;
  logic [5:0]            w_arg;
  logic                  w_argValid;
  logic [7:0]            w_status;

  assign w_capture  = ir_is_user & capture_dr;
  assign w_shift    = ir_is_user & shift_dr;
  assign w_update   = ir_is_user & update_dr;
  assign w_opcode   = opcode_t'(r_sr[7:6]);
  assign w_arg      = r_sr[5:0];
  assign w_argValid = ({26'd0, w_arg} < 32'(CHANNELS));
  assign w_status   = {r_cmdError, w_overflow[r_sel], 6'(r_sel)};

  always_ff @(posedge tck) begin
    if (!test_logic_reset_n) begin
      r_sr <= '0;
    end else if (w_capture) begin
      r_sr <= {w_count[r_sel], w_status};
    end else if (w_shift) begin
      r_sr <= {tdi, r_sr[SR_W-1:1]};
    end
  end

  // Command decode; an out-of-range SELECT keeps the old channel and flags the error.
  always_ff @(posedge tck) begin
    if (!test_logic_reset_n) begin
      r_sel      <= '0;
      r_cmdError <= 1'b0;
      r_enable   <= '1;
    end else if (w_update) begin
      case (w_opcode)
        OP_SELECT: begin
          if (w_argValid) begin
            r_sel      <= w_arg[SEL_W-1:0];
            r_cmdError <= 1'b0;
          end else begin
            r_cmdError <= 1'b1;
          end
        end
        OP_CLEAR: begin
          r_cmdError <= 1'b0;
        end
        OP_ENABLE: begin
          r_enable   <= r_sr[CHANNELS+7:8];
          r_cmdError <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic [DATA_WIDTH-1:0] r_cnt;
      logic                  r_ovf;
      logic                  w_clearHit;

      assign w_clearHit = w_update && (w_opcode == OP_CLEAR) && (r_sel == SEL_W'(i));

      // Saturating counter: all-ones is terminal and latches the sticky flag.
      always_ff @(posedge tck) begin
        if (!test_logic_reset_n) begin
          r_cnt <= '0;
          r_ovf <= 1'b0;
        end else if (w_clearHit) begin
          r_cnt <= '0;
          r_ovf <= 1'b0;
        end else if (run_test_idle && r_enable[i]) begin
          if (&r_cnt) begin
            r_ovf <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_count[i]    = r_cnt;
      assign w_overflow[i] = r_ovf;
    end
  endgenerate

  assign tdo       = r_sr[0];
  assign sel_count = w_count[r_sel];
  assign overflow  = w_overflow;

endmodule
